// File: rtl/program_top_pkg.sv
// Shared constants, FSM state type and small datapath helpers for the
// program_top three-task compute engine.
package program_top_pkg;

    localparam logic [7:0] A_ADDR   = 8'd1;
    localparam logic [7:0] B_ADDR   = 8'd2;
    localparam logic [7:0] C_ADDR   = 8'd3;
    localparam logic [7:0] PH_ADDR  = 8'd4;
    localparam logic [7:0] PL_ADDR  = 8'd5;
    localparam logic [7:0] PAT_ADDR = 8'd6;
    localparam logic [7:0] CT_ADDR  = 8'd7;
    localparam logic [7:0] SRCH_LO  = 8'd32;
    localparam logic [7:0] SRCH_HI  = 8'd95;
    localparam logic [7:0] DIST_OUT = 8'd127;
    localparam logic [7:0] DIST_LO  = 8'd128;
    localparam logic [7:0] DIST_HI  = 8'd147;

    typedef enum logic [1:0] {
        S_P1   = 2'd0,
        S_P2   = 2'd1,
        S_P3   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // True when any of the five 4-bit windows of the byte equals the nibble.
    function automatic logic nib_match(input logic [7:0] b, input logic [3:0] p);
        logic m;
        m = 1'b0;
        for (int s = 0; s < 5; s++) begin
            m = m | (b[s +: 4] == p);
        end
        return m;
    endfunction

    // |x - y| via a 9-bit signed difference; the magnitude always fits 8 bits.
    function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
        logic signed [8:0] d;
        logic signed [8:0] n;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        n = -d;
        if (d < 9'sd0) begin
            return n[7:0];
        end else begin
            return d[7:0];
        end
    endfunction

endpackage

// File: rtl/program_top_dmem.sv
// Single-port 2**AW x DW data memory: combinational read, synchronous write,
// deliberately without reset so contents can be preloaded while the engine is held.
module dmem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] guts [0:(1<<AW)-1];

    assign rdata_o = guts[addr_i];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            guts[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/program_top.sv
// Three-task engine (multiply, nibble-pattern count, minimum pair distance)
// over a private data memory. Optional CYCLE_COUNT_EN adds the cycle_ct output.
module program_top
    import program_top_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        done
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0] cycle_ct
`endif
);

    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [15:0]   acc_q, acc_d;
    logic [3:0]    pat_q, pat_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    j_q, j_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    min_q, min_d;
    logic          done_q, done_d;

    logic [AW-1:0] addr_s;
    logic          we_s;
    logic [DW-1:0] wd_s;
    logic [DW-1:0] rd_s;
    logic [7:0]    dist_s;

    dmem #(.DW(DW), .AW(AW)) dm1 (
        .clk     (clk),
        .we_i    (we_s & reset),
        .addr_i  (addr_s),
        .wdata_i (wd_s),
        .rdata_o (rd_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_P1;
            phase_q <= 3'd0;
            acc_q   <= 16'h0000;
            pat_q   <= 4'h0;
            cnt_q   <= 7'd0;
            idx_q   <= 8'h00;
            j_q     <= 8'h00;
            hold_q  <= 8'h00;
            min_q   <= 8'hFF;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            hold_q  <= hold_d;
            min_q   <= min_d;
            done_q  <= done_d;
        end
    end

    // Next-state, memory access and datapath update; one memory access per cycle.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        j_d     = j_q;
        hold_d  = hold_q;
        min_d   = min_q;
        done_d  = done_q;
        addr_s  = 8'h00;
        we_s    = 1'b0;
        wd_s    = 8'h00;
        dist_s  = abs_diff(rd_s, hold_q);
        case (state_q)
            S_P1: begin
                case (phase_q)
                    3'd0: begin addr_s = A_ADDR; acc_d = {8'h00, rd_s}; phase_d = 3'd1; end
                    3'd1: begin addr_s = B_ADDR; acc_d = acc_q * {8'h00, rd_s}; phase_d = 3'd2; end
                    3'd2: begin addr_s = C_ADDR; acc_d = acc_q * {8'h00, rd_s}; phase_d = 3'd3; end
                    3'd3: begin addr_s = PH_ADDR; we_s = 1'b1; wd_s = acc_q[15:8]; phase_d = 3'd4; end
                    3'd4: begin
                        addr_s  = PL_ADDR;
                        we_s    = 1'b1;
                        wd_s    = acc_q[7:0];
                        state_d = S_P2;
                        phase_d = 3'd0;
                    end
                    default: phase_d = 3'd0;
                endcase
            end
            S_P2: begin
                case (phase_q)
                    3'd0: begin
                        addr_s  = PAT_ADDR;
                        pat_d   = rd_s[3:0];
                        idx_d   = SRCH_LO;
                        cnt_d   = 7'd0;
                        phase_d = 3'd1;
                    end
                    3'd1: begin
                        addr_s = idx_q;
                        if (nib_match(rd_s, pat_q)) begin
                            cnt_d = cnt_q + 7'd1;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (idx_q == SRCH_HI) begin
                            phase_d = 3'd2;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                    3'd2: begin
                        addr_s  = CT_ADDR;
                        we_s    = 1'b1;
                        wd_s    = {1'b0, cnt_q};
                        state_d = S_P3;
                        phase_d = 3'd0;
                        j_d     = DIST_LO;
                        min_d   = 8'hFF;
                    end
                    default: phase_d = 3'd0;
                endcase
            end
            S_P3: begin
                // Latch element j, then stream every k > j against it.
                case (phase_q)
                    3'd0: begin
                        addr_s  = j_q;
                        hold_d  = rd_s;
                        idx_d   = j_q + 8'd1;
                        phase_d = 3'd1;
                    end
                    3'd1: begin
                        addr_s = idx_q;
                        if (dist_s < min_q) begin
                            min_d = dist_s;
                        end else begin
                            min_d = min_q;
                        end
                        if (idx_q != DIST_HI) begin
                            idx_d = idx_q + 8'd1;
                        end else if (j_q == DIST_HI - 8'd1) begin
                            phase_d = 3'd2;
                        end else begin
                            j_d     = j_q + 8'd1;
                            phase_d = 3'd0;
                        end
                    end
                    3'd2: begin
                        addr_s  = DIST_OUT;
                        we_s    = 1'b1;
                        wd_s    = min_q;
                        state_d = S_DONE;
                        phase_d = 3'd0;
                        done_d  = 1'b1;
                    end
                    default: phase_d = 3'd0;
                endcase
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_P1;
                phase_d = 3'd0;
            end
        endcase
    end

    assign done = done_q;

`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    // Run-length counter, frozen once done is registered.
    always_comb begin
        if (done_q) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_ct = cyc_q;
`endif

endmodule

// File: tb/tb_program_top.sv
// Self-checking bench for program_top: preloads the data memory, runs the
// engine and compares results against a behavioural model of the three tasks.
module tb_program_top;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;
`ifdef CYCLE_COUNT_EN
    logic [15:0] cycle_ct;
    logic [15:0] ref_ct;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ref_cyc = -1;
    logic [7:0] img [0:255];

    program_top dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
`ifdef CYCLE_COUNT_EN
        ,
        .cycle_ct (cycle_ct)
`endif
    );

    always #5 clk = ~clk;

    task automatic rand_img();
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_img();
        for (int i = 0; i < 256; i++) dut.dm1.guts[i] = img[i];
    endtask

    function automatic int exp_prod();
        return (int'(img[1]) * int'(img[2]) * int'(img[3])) % 65536;
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 32; i <= 95; i++) begin
            bit hit = 1'b0;
            for (int s = 0; s < 5; s++)
                if (((int'(img[i]) >> s) & 15) == (int'(img[6]) & 15)) hit = 1'b1;
            if (hit) c++;
        end
        return c;
    endfunction

    function automatic int exp_min();
        int m = 255;
        for (int j = 128; j < 147; j++)
            for (int k = j + 1; k <= 147; k++) begin
                int d = int'(img[k]) - int'(img[j]);
                if (d < 0) d = -d;
                if (d < m) m = d;
            end
        return m;
    endfunction

    // Releases reset and waits a bounded number of cycles for done.
    task automatic run(output int cyc, output bit to);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        to = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        rand_img();
        load_img();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (dut.dm1.guts[i] !== img[i]) begin
                n_bad++; $display("FAIL reset_nowrite[%0d] got %h exp %h", i, dut.dm1.guts[i], img[i]);
            end
        end
`ifdef CYCLE_COUNT_EN
        n_cmp++;
        if (cycle_ct !== 16'd0) begin n_bad++; $display("FAIL reset_ct got %0d exp 0", cycle_ct); end
`endif
    endtask

    task automatic test_multiply();
        int ta [3] = '{255, 5, 0};
        int tb [3] = '{255, 15, 77};
        int tc [3] = '{200, 2, 9};
        int ph [3] = '{8'h70, 8'h00, 8'h00};
        int pl [3] = '{8'hC8, 8'h96, 8'h00};
        int cyc; bit to;
        for (int t = 0; t < 3; t++) begin
            hold_reset();
            rand_img();
            img[1] = 8'(ta[t]); img[2] = 8'(tb[t]); img[3] = 8'(tc[t]);
            load_img();
            run(cyc, to);
            n_cmp++;
            if (to || cyc >= 1000) begin n_bad++; $display("FAIL mul_latency got %0d exp <1000 (timeout %b)", cyc, to); end
            n_cmp++;
            if (dut.dm1.guts[4] !== 8'(ph[t])) begin n_bad++; $display("FAIL mul_hi[%0d] got %h exp %h", t, dut.dm1.guts[4], ph[t]); end
            n_cmp++;
            if (dut.dm1.guts[5] !== 8'(pl[t])) begin n_bad++; $display("FAIL mul_lo[%0d] got %h exp %h", t, dut.dm1.guts[5], pl[t]); end
            if (ref_cyc < 0) ref_cyc = cyc;
`ifdef CYCLE_COUNT_EN
            if (t == 0) ref_ct = cycle_ct;
`endif
        end
    endtask

    task automatic test_pattern();
        int cyc; bit to;
        for (int t = 0; t < 2; t++) begin
            hold_reset();
            rand_img();
            img[6] = 8'h0D;
            for (int i = 32; i <= 95; i++) img[i] = (t == 0) ? 8'h00 : 8'h0D;
            if (t == 0) begin img[40] = 8'hD0; img[41] = 8'h1A; img[42] = 8'hDD; end
            load_img();
            run(cyc, to);
            n_cmp++;
            if (to) begin n_bad++; $display("FAIL pat_timeout got timeout exp done"); end
            n_cmp++;
            if (dut.dm1.guts[7] !== ((t == 0) ? 8'd3 : 8'd64)) begin
                n_bad++; $display("FAIL pat_count[%0d] got %0d exp %0d", t, dut.dm1.guts[7], (t == 0) ? 3 : 64);
            end
        end
    endtask

    task automatic test_distance();
        int expv [3] = '{10, 5, 0};
        int cyc; bit to;
        for (int t = 0; t < 3; t++) begin
            hold_reset();
            rand_img();
            for (int i = 0; i < 20; i++) img[128 + i] = 8'(10 * (i + 1));
            if (t >= 1) img[147] = 8'd55;
            if (t == 2) img[145] = img[131];
            load_img();
            run(cyc, to);
            n_cmp++;
            if (to) begin n_bad++; $display("FAIL dist_timeout got timeout exp done"); end
            n_cmp++;
            if (dut.dm1.guts[127] !== 8'(expv[t])) begin
                n_bad++; $display("FAIL dist_min[%0d] got %0d exp %0d", t, dut.dm1.guts[127], expv[t]);
            end
        end
    endtask

    task automatic test_random();
        int cyc; bit to;
        for (int t = 0; t < 6; t++) begin
            hold_reset();
            rand_img();
            if (t >= 3) for (int i = 128; i <= 147; i++) img[i] = 8'($urandom_range(0, 15) * 17);
            load_img();
            run(cyc, to);
            n_cmp++;
            if (to || cyc != ref_cyc) begin n_bad++; $display("FAIL rnd_cycles got %0d exp %0d", cyc, ref_cyc); end
            n_cmp++;
            if ({dut.dm1.guts[4], dut.dm1.guts[5]} !== 16'(exp_prod())) begin
                n_bad++; $display("FAIL rnd_prod got %h%h exp %h", dut.dm1.guts[4], dut.dm1.guts[5], exp_prod());
            end
            n_cmp++;
            if (dut.dm1.guts[7] !== 8'(exp_cnt())) begin n_bad++; $display("FAIL rnd_cnt got %0d exp %0d", dut.dm1.guts[7], exp_cnt()); end
            n_cmp++;
            if (dut.dm1.guts[127] !== 8'(exp_min())) begin n_bad++; $display("FAIL rnd_min got %0d exp %0d", dut.dm1.guts[127], exp_min()); end
            for (int i = 0; i < 256; i++) begin
                if (i == 4 || i == 5 || i == 7 || i == 127) continue;
                n_cmp++;
                if (dut.dm1.guts[i] !== img[i]) begin n_bad++; $display("FAIL rnd_untouched[%0d] got %h exp %h", i, dut.dm1.guts[i], img[i]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int cyc; bit to;
        hold_reset();
        rand_img();
        load_img();
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b exp 0", done); end
        @(negedge clk);
        run(cyc, to);
        n_cmp++;
        if (to || cyc != ref_cyc) begin n_bad++; $display("FAIL mid_cycles got %0d exp %0d", cyc, ref_cyc); end
        n_cmp++;
        if ({dut.dm1.guts[4], dut.dm1.guts[5]} !== 16'(exp_prod())) begin
            n_bad++; $display("FAIL mid_prod got %h%h exp %h", dut.dm1.guts[4], dut.dm1.guts[5], exp_prod());
        end
        n_cmp++;
        if (dut.dm1.guts[7] !== 8'(exp_cnt())) begin n_bad++; $display("FAIL mid_cnt got %0d exp %0d", dut.dm1.guts[7], exp_cnt()); end
        n_cmp++;
        if (dut.dm1.guts[127] !== 8'(exp_min())) begin n_bad++; $display("FAIL mid_min got %0d exp %0d", dut.dm1.guts[127], exp_min()); end
        for (int i = 0; i < 256; i++) begin
            if (i == 4 || i == 5 || i == 7 || i == 127) continue;
            n_cmp++;
            if (dut.dm1.guts[i] !== img[i]) begin n_bad++; $display("FAIL mid_untouched[%0d] got %h exp %h", i, dut.dm1.guts[i], img[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit to;
        logic [7:0] r4, r5, r7, r127;
        r4 = dut.dm1.guts[4]; r5 = dut.dm1.guts[5]; r7 = dut.dm1.guts[7]; r127 = dut.dm1.guts[127];
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_hold got %b exp 1", done); end
        n_cmp++;
        if ({dut.dm1.guts[4], dut.dm1.guts[5], dut.dm1.guts[7], dut.dm1.guts[127]} !== {r4, r5, r7, r127}) begin
            n_bad++; $display("FAIL b2b_stable got %h exp %h", {dut.dm1.guts[4], dut.dm1.guts[5], dut.dm1.guts[7], dut.dm1.guts[127]}, {r4, r5, r7, r127});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got %b exp 0", done); end
        @(negedge clk);
        rand_img();
        load_img();
        run(cyc, to);
        n_cmp++;
        if (to || cyc != ref_cyc) begin n_bad++; $display("FAIL b2b_cycles got %0d exp %0d", cyc, ref_cyc); end
        n_cmp++;
        if ({dut.dm1.guts[4], dut.dm1.guts[5]} !== 16'(exp_prod())) begin
            n_bad++; $display("FAIL b2b_prod got %h%h exp %h", dut.dm1.guts[4], dut.dm1.guts[5], exp_prod());
        end
        n_cmp++;
        if (dut.dm1.guts[7] !== 8'(exp_cnt())) begin n_bad++; $display("FAIL b2b_cnt got %0d exp %0d", dut.dm1.guts[7], exp_cnt()); end
        n_cmp++;
        if (dut.dm1.guts[127] !== 8'(exp_min())) begin n_bad++; $display("FAIL b2b_min got %0d exp %0d", dut.dm1.guts[127], exp_min()); end
`ifdef CYCLE_COUNT_EN
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cycle_ct !== ref_ct) begin n_bad++; $display("FAIL b2b_ct got %0d exp %0d", cycle_ct, ref_ct); end
`endif
    endtask

    initial begin
        #1 reset = 1'b0;
        test_reset();
        test_multiply();
        test_pattern();
        test_distance();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/program_top.md
Name: program_top

Overview:
- Fixed-function, three-task compute engine with its own 256x8 data memory.
- After reset is released it runs three tasks in order, then raises done:
  - multiplies three bytes;
  - counts bytes that contain a 4-bit pattern;
  - finds the minimum absolute difference over 20 bytes.
- The bench preloads operands into the data memory and reads results back from it by hierarchical access.

Parameters:
- DW, 8, data word width.
- AW, 8, data memory address width (2**AW words).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 holds the engine in reset.
- done  output  1  all three results written; held high until the next reset.

Behaviour:
- Data memory:
  - Instance dm1, array guts[0:255] of DW bits, inside sub-module dmem.
  - Combinational read, synchronous write, one port.
  - Never reset: contents survive reset so the bench can preload while reset is asserted.
- Memory map:
  - 1,2,3 = a,b,c.
  - 4,5 = product high,low.
  - 6 = pattern (bits [3:0]).
  - 7 = match count.
  - 32..95 = search data.
  - 127 = min distance.
  - 128..147 = distance data.
- Reset (reset=0): FSM goes to S_P1, done=0, all counters and accumulators clear. No memory write while reset=0.
- FSM sequence: S_P1 -> S_P2 -> S_P3 -> S_DONE. Each task performs one memory access per cycle.
- S_P1 (multiply):
  - Read a, b, c.
  - p = (a*b*c) mod 2**16, unsigned.
  - Write p[15:8] to address 4, then p[7:0] to address 5.
- S_P2 (pattern count):
  - Read pattern nibble P = mem[6][3:0].
  - For each address 32..95: the byte matches if any window [3:0],[4:1],[5:2],[6:3],[7:4] equals P.
  - Each byte counts at most once. Count range 0..64.
  - Write count to address 7.
- S_P3 (minimum distance):
  - Over all unordered pairs (j<k) in 128..147 (190 pairs), d = |mem[k]-mem[j]|, computed as a 9-bit signed difference then absolute value.
  - min initialised to 255. Duplicate values give 0.
  - Write the 8-bit min to address 127.
- S_DONE: done=1, no further memory writes, stays until reset.
- Latency: deterministic. Total cycles from reset release to done must be under 1000.
- Reset mid-operation: aborts immediately, done=0. Restarts from S_P1 on release and rewrites all results. Partially written results from the aborted run are overwritten.
- Writes touch only addresses 4, 5, 7, 127.

Optional Feature:
- Macro CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_ct[15:0].
  - Cleared by reset; increments every clock while done=0; freezes when done rises.
- Undefined: no port and no counter; behaviour otherwise identical.

Decomposition:
- Package program_top_pkg holds:
  - address constants: A_ADDR=1, B_ADDR=2, C_ADDR=3, PH_ADDR=4, PL_ADDR=5, PAT_ADDR=6, CT_ADDR=7, SRCH_LO=32, SRCH_HI=95, DIST_OUT=127, DIST_LO=128, DIST_HI=147;
  - FSM state enum typedef state_t.
- One sub-module, dmem (instance dm1, array guts). Instance name and array name are fixed for bench access.
- FSM and datapath stay in program_top.

Test Plan:
- Multiply wrap: a=255, b=255, c=200 -> mem[4]=0x70, mem[5]=0xC8 (28872); done=1.
- Multiply small: a=5, b=15, c=2 -> mem[4]=0x00, mem[5]=0x96 (150).
- Pattern count:
  - pattern 0x0D, mem[32..95]=0x00 except mem[40]=0xD0, mem[41]=0x1A, mem[42]=0xDD -> mem[7]=3 (0xDD counted once).
  - All 64 = 0x0D -> mem[7]=64.
- Minimum distance:
  - mem[128..147]=10,20,...,200 -> mem[127]=10.
  - Then mem[147]=55 -> mem[127]=5.
  - Any duplicate pair -> mem[127]=0.
- Reset mid-run: drop reset during S_P2 -> done=0 within the same cycle; on release all results are recomputed correctly; mem[0], mem[8..31], mem[96..126], mem[148..255] are unchanged.
- Back-to-back runs: change operands while reset=0, release; done stays high until the next reset and results reflect the new operands (with CYCLE_COUNT_EN defined, cycle_ct is identical across runs).
